// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types and constants for the FPU result queue slice.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [1:0] {
        UNIT_ADD  = 2'b00,
        UNIT_MUL  = 2'b01,
        UNIT_DIV  = 2'b10,
        UNIT_RSVD = 2'b11
    } fpu_unit_e;

    localparam int FLAGS_W = 5;
    // Flag vector order is {NV,DZ,OF,UF,NX}, so invalid-operation is the MSB
    localparam int FLAG_NV = 4;
    localparam logic [FLAGS_W-1:0] NV_FLAGS = FLAGS_W'(1) << FLAG_NV;

    localparam int MAN_WIDTH_DEF = 23;
    localparam int EXP_WIDTH_DEF = 8;
    localparam int TAG_WIDTH_DEF = 4;
    localparam int DW_DEF        = MAN_WIDTH_DEF + EXP_WIDTH_DEF + 1;

    typedef struct packed {
        logic [DW_DEF-1:0]        data;
        logic [FLAGS_W-1:0]       flags;
        logic [TAG_WIDTH_DEF-1:0] tag;
    } fpu_res_t;

endpackage
`default_nettype wire

// File: rtl/fpu_result_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_queue_if
// Description : Controller-side and CPU-side signals of the result queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_result_queue_if
    import fpu_pkg::*;
#(
    parameter int DW        = 32,
    parameter int TAG_WIDTH = 4,
    parameter int CNT_W     = 3
);
    logic                 res_valid;
    logic [1:0]           demux_control;
    logic [TAG_WIDTH-1:0] tag_i;
    logic [DW-1:0]        add_res;
    logic [DW-1:0]        mul_res;
    logic [DW-1:0]        div_res;
    logic [FLAGS_W-1:0]   add_flags;
    logic [FLAGS_W-1:0]   mul_flags;
    logic [FLAGS_W-1:0]   div_flags;
    logic                 flush;
    logic                 res_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [FLAGS_W-1:0]   out_flags;
    logic [TAG_WIDTH-1:0] out_tag;
    logic [CNT_W-1:0]     count;
    logic                 overflow;

    modport master (
        output res_valid, demux_control, tag_i, add_res, mul_res, div_res,
               add_flags, mul_flags, div_flags, flush, out_ready,
        input  res_ready, out_valid, out_data, out_flags, out_tag, count, overflow
    );

    modport slave (
        input  res_valid, demux_control, tag_i, add_res, mul_res, div_res,
               add_flags, mul_flags, div_flags, flush, out_ready,
        output res_ready, out_valid, out_data, out_flags, out_tag, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fpu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sync_fifo
// Description : Generic DEPTH x WIDTH FIFO with flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic                     flush,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic      [WIDTH-1:0]         rdata,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end
endmodule
`default_nettype wire

// File: rtl/fpu_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_queue
// Description : Unit-select mux, tagged result FIFO and CPU handshake.
//               Optional same-cycle bypass when FPU_RESQ_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int MAN_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fpu_result_queue_if.slave bus
);
    localparam int DW    = MAN_WIDTH + EXP_WIDTH + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0]        data;
        logic [FLAGS_W-1:0]   flags;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t           w_new_entry;
    entry_t           w_head_entry;
    entry_t           w_out_entry;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic [CNT_W-1:0] w_count;
    logic             r_overflow;

    always_comb begin
        w_new_entry.data  = '0;
        w_new_entry.flags = NV_FLAGS;
        w_new_entry.tag   = bus.tag_i;
        case (fpu_unit_e'(bus.demux_control))
            UNIT_ADD: begin
                w_new_entry.data  = bus.add_res;
                w_new_entry.flags = bus.add_flags;
            end
            UNIT_MUL: begin
                w_new_entry.data  = bus.mul_res;
                w_new_entry.flags = bus.mul_flags;
            end
            UNIT_DIV: begin
                w_new_entry.data  = bus.div_res;
                w_new_entry.flags = bus.div_flags;
            end
            default: ;
        endcase
    end

`ifdef FPU_RESQ_BYPASS_EN
    // A bypassed result is consumed this cycle, so it must not also be stored
    assign w_bypass    = w_empty && bus.res_valid && bus.out_ready && !bus.flush;
    assign w_out_entry = w_bypass ? w_new_entry : (w_empty ? entry_t'('0) : w_head_entry);
`else
    assign w_bypass    = 1'b0;
    assign w_out_entry = w_empty ? entry_t'('0) : w_head_entry;
`endif

    assign w_push = bus.res_valid && !w_full && !w_bypass;
    assign w_pop  = bus.out_ready && !w_empty;

    fpu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.flush),
        .wdata (w_new_entry),
        .rdata (w_head_entry),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_overflow <= 1'b0;
        else if (bus.res_valid && w_full) r_overflow <= 1'b1;
    end

    assign bus.res_ready = !w_full;
    assign bus.out_valid = !w_empty || w_bypass;
    assign bus.out_data  = w_out_entry.data;
    assign bus.out_flags = w_out_entry.flags;
    assign bus.out_tag   = w_out_entry.tag;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire
